// File: rtl/rsa_job_arbiter.sv
// Two-requester round-robin front end for a shared RSA datapath: accepts one job,
// sequences clear/run, and returns the result or a timeout/abort code to the owner.
module rsa_job_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ena,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_p,
    input  logic [2*WIDTH-1:0] req_e,
    input  logic [2*WIDTH-1:0] req_m,
    input  logic [2*WIDTH-1:0] req_const,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_c,
    output logic [1:0]         rsp_status,
    input  logic               abort,
    output logic [WIDTH-1:0]   rsa_p,
    output logic [WIDTH-1:0]   rsa_e,
    output logic [WIDTH-1:0]   rsa_m,
    output logic [WIDTH-1:0]   rsa_const,
    output logic               rsa_clear,
    output logic               rsa_en,
    input  logic               rsa_eoc,
    input  logic [WIDTH-1:0]   rsa_c,
    output logic               busy,
    output logic               grant_id
);

    localparam logic [1:0] STATUS_OK      = 2'b00;
    localparam logic [1:0] STATUS_TIMEOUT = 2'b01;
    localparam logic [1:0] STATUS_ABORT   = 2'b10;
    localparam logic [7:0] CNT_LAST       = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, CLEAR, RUN, RESP} state_t;

    state_t     state, state_next;
    logic       ptr;
    logic       pick;
    logic       take;
    logic       capture;
    logic [1:0] status_next;
    logic [7:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (ena) begin
            state <= state_next;
        end
    end

    // ptr holds the last granted requester; on contention the other one wins.
    always_comb begin
        state_next  = state;
        req_ready   = '0;
        rsa_clear   = 1'b0;
        rsa_en      = 1'b0;
        take        = 1'b0;
        capture     = 1'b0;
        status_next = rsp_status;
        cnt_next    = cnt;
        pick        = (req_valid == 2'b11) ? ~ptr : req_valid[1];

        case (state)
            IDLE: begin
                if (|req_valid) begin
                    take       = 1'b1;
                    req_ready  = pick ? 2'b10 : 2'b01;
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                rsa_clear = 1'b1;
                cnt_next  = '0;
                if (abort) begin
                    status_next = STATUS_ABORT;
                    state_next  = RESP;
                end else begin
                    state_next = RUN;
                end
            end
            RUN: begin
                rsa_en   = 1'b1;
                cnt_next = cnt + 8'd1;
                if (rsa_eoc) begin
                    capture     = 1'b1;
                    status_next = STATUS_OK;
                    state_next  = RESP;
                end else if (abort) begin
                    status_next = STATUS_ABORT;
                    state_next  = RESP;
                end else if (cnt == CNT_LAST) begin
                    status_next = STATUS_TIMEOUT;
                    state_next  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready[grant_id]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (rst || !ena) begin
            req_ready = '0;
            rsa_clear = 1'b0;
            rsa_en    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr        <= 1'b1;
            cnt        <= '0;
            grant_id   <= 1'b0;
            rsp_c      <= '0;
            rsp_status <= STATUS_OK;
            rsa_p      <= '0;
            rsa_e      <= '0;
            rsa_m      <= '0;
            rsa_const  <= '0;
        end else if (ena) begin
            cnt        <= cnt_next;
            rsp_status <= status_next;
            if (capture) begin
                rsp_c <= rsa_c;
            end
            if (take) begin
                grant_id  <= pick;
                ptr       <= pick;
                rsa_p     <= pick ? req_p[2*WIDTH-1:WIDTH]     : req_p[WIDTH-1:0];
                rsa_e     <= pick ? req_e[2*WIDTH-1:WIDTH]     : req_e[WIDTH-1:0];
                rsa_m     <= pick ? req_m[2*WIDTH-1:WIDTH]     : req_m[WIDTH-1:0];
                rsa_const <= pick ? req_const[2*WIDTH-1:WIDTH] : req_const[WIDTH-1:0];
            end
        end
    end

    assign rsp_valid = (state == RESP) ? (grant_id ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Directed bench for rsa_job_arbiter: default instance for job flow, a TIMEOUT=4
// instance for the timeout/enable-freeze scenario.
module tb_rsa_job_arbiter;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst, ena, abort, rsa_eoc;
    logic [1:0]     req_valid, rsp_ready, req_valid_t, rsp_ready_t;
    logic [2*W-1:0] req_p, req_e, req_m, req_const;
    logic [W-1:0]   rsa_c;

    logic [1:0]     req_ready, rsp_valid, rsp_status;
    logic [W-1:0]   rsp_c, rsa_p, rsa_e, rsa_m, rsa_const;
    logic           rsa_clear, rsa_en, busy, grant_id;

    logic [1:0]     req_ready_t, rsp_valid_t, rsp_status_t;
    logic [W-1:0]   rsp_c_t, rsa_p_t, rsa_e_t, rsa_m_t, rsa_const_t;
    logic           rsa_clear_t, rsa_en_t, busy_t, grant_id_t;

    int n_asserts = 0;
    int n_fail    = 0;
    int en_cnt;

    always #5 clk = ~clk;

    rsa_job_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_p(req_p), .req_e(req_e), .req_m(req_m), .req_const(req_const),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_status(rsp_status),
        .abort(abort),
        .rsa_p(rsa_p), .rsa_e(rsa_e), .rsa_m(rsa_m), .rsa_const(rsa_const),
        .rsa_clear(rsa_clear), .rsa_en(rsa_en), .rsa_eoc(rsa_eoc), .rsa_c(rsa_c),
        .busy(busy), .grant_id(grant_id)
    );

    rsa_job_arbiter #(.WIDTH(W), .TIMEOUT(4)) dut_to (
        .clk(clk), .rst(rst), .ena(ena),
        .req_valid(req_valid_t), .req_ready(req_ready_t),
        .req_p(req_p), .req_e(req_e), .req_m(req_m), .req_const(req_const),
        .rsp_valid(rsp_valid_t), .rsp_ready(rsp_ready_t), .rsp_c(rsp_c_t), .rsp_status(rsp_status_t),
        .abort(1'b0),
        .rsa_p(rsa_p_t), .rsa_e(rsa_e_t), .rsa_m(rsa_m_t), .rsa_const(rsa_const_t),
        .rsa_clear(rsa_clear_t), .rsa_en(rsa_en_t), .rsa_eoc(1'b0), .rsa_c(rsa_c),
        .busy(busy_t), .grant_id(grant_id_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; abort = 1'b0; rsa_eoc = 1'b0; rsa_c = '0;
        req_valid = '0; rsp_ready = '0; req_valid_t = '0; rsp_ready_t = '0;
        req_p     = {8'hA1, 8'h0B};
        req_e     = {8'hA2, 8'h07};
        req_m     = {8'hA3, 8'h05};
        req_const = {8'hA4, 8'h04};
        tick(); tick();

        // reset state, with requests present to show rst dominance
        req_valid = 2'b11; #1;
        check("rst_req_ready", req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 2'b00);
        check("rst_rsp_c", rsp_c, 8'h00);
        check("rst_status", rsp_status, 2'b00);
        check("rst_rsa_p", rsa_p, 8'h00);
        check("rst_grant", grant_id, 1'b0);
        check("rst_en_clear", {rsa_en, rsa_clear}, 2'b00);

        // contention: 0 first, then 1
        rst = 1'b0; #1;
        check("cont_ready0", req_ready, 2'b01);
        tick();
        check("cont_clear0", {rsa_clear, rsa_en}, 2'b10);
        check("cont_grant0", grant_id, 1'b0);
        check("cont_p0", rsa_p, 8'h0B);
        check("cont_busy", busy, 1'b1);
        check("cont_noready_busy", req_ready, 2'b00);
        tick();
        check("cont_run0", {rsa_clear, rsa_en}, 2'b01);
        rsa_eoc = 1'b1; rsa_c = 8'h11;
        tick();
        rsa_eoc = 1'b0; #1;
        check("cont_rsp0_valid", rsp_valid, 2'b01);
        check("cont_rsp0_c", rsp_c, 8'h11);
        check("cont_rsp0_en", rsa_en, 1'b0);
        rsp_ready = 2'b10;
        tick();
        check("cont_rsp0_wrong_ready", rsp_valid, 2'b01);
        rsp_ready = 2'b01;
        tick();
        check("cont_idle_busy", busy, 1'b0);
        check("cont_ready1", req_ready, 2'b10);
        rsp_ready = 2'b00;
        tick();
        check("cont_grant1", grant_id, 1'b1);
        check("cont_p1", rsa_p, 8'hA1);
        check("cont_m1", rsa_m, 8'hA3);
        tick();
        rsa_eoc = 1'b1; rsa_c = 8'h22;
        tick();
        rsa_eoc = 1'b0; #1;
        check("cont_rsp1_valid", rsp_valid, 2'b10);
        check("cont_rsp1_c", rsp_c, 8'h22);
        rsp_ready = 2'b01;
        tick();
        check("cont_rsp1_wrong_ready", rsp_valid, 2'b10);
        rsp_ready = 2'b10;
        tick();
        req_valid = 2'b00; rsp_ready = 2'b00;
        tick();
        check("withdraw_idle", busy, 1'b0);

        // single job: eoc in 10th RUN cycle -> response at T+12
        req_valid = 2'b01; #1;
        check("single_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; #1;
        check("single_clear", rsa_clear, 1'b1);
        check("single_e", rsa_e, 8'h07);
        check("single_const", rsa_const, 8'h04);
        tick();
        check("single_first_en", rsa_en, 1'b1);
        repeat (9) tick();
        check("single_en_t11", rsa_en, 1'b1);
        check("single_not_early", rsp_valid, 2'b00);
        rsa_eoc = 1'b1; rsa_c = 8'h5A;
        tick();
        rsa_eoc = 1'b0; #1;
        check("single_rsp_valid", rsp_valid, 2'b01);
        check("single_rsp_c", rsp_c, 8'h5A);
        check("single_status", rsp_status, 2'b00);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // eoc beats abort in the same RUN cycle
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00;
        tick();
        abort = 1'b1; rsa_eoc = 1'b1; rsa_c = 8'h3C;
        tick();
        abort = 1'b0; rsa_eoc = 1'b0; #1;
        check("eoc_abort_status", rsp_status, 2'b00);
        check("eoc_abort_c", rsp_c, 8'h3C);
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // abort in CLEAR
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00; abort = 1'b1; #1;
        check("abort_clear_en", rsa_en, 1'b0);
        tick();
        abort = 1'b0; #1;
        check("abort_status", rsp_status, 2'b10);
        check("abort_valid", rsp_valid, 2'b10);
        check("abort_en", rsa_en, 1'b0);
        check("abort_c_kept", rsp_c, 8'h3C);
        rsp_ready = 2'b10;
        tick();
        rsp_ready = 2'b00;

        // abort while idle is ignored
        abort = 1'b1;
        tick();
        abort = 1'b0; #1;
        check("abort_idle", {busy, rsp_valid}, 3'b000);

        // ena=0 during CLEAR and for 5 RUN cycles
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00; ena = 1'b0; #1;
        check("freeze_clear_gated", rsa_clear, 1'b0);
        tick();
        check("freeze_clear_held", {busy, rsa_clear}, 2'b10);
        ena = 1'b1; #1;
        check("freeze_clear_resume", rsa_clear, 1'b1);
        tick();
        tick();
        ena = 1'b0;
        en_cnt = 0;
        repeat (5) begin
            tick();
            if (rsa_en || rsp_valid != 2'b00) en_cnt++;
        end
        check("freeze_run_en", en_cnt, 0);
        ena = 1'b1; #1;
        check("freeze_run_resume", rsa_en, 1'b1);
        rsa_eoc = 1'b1; rsa_c = 8'h77;
        tick();
        rsa_eoc = 1'b0; #1;
        check("freeze_rsp_c", {rsp_valid, rsp_c}, {2'b01, 8'h77});
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00;

        // TIMEOUT=4 instance, with a 5-cycle ena gap mid-RUN
        req_valid_t = 2'b01;
        tick();
        req_valid_t = 2'b00;
        en_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            ena = (i >= 3 && i < 8) ? 1'b0 : 1'b1;
            #1;
            if (rsa_en_t) en_cnt++;
            if (rsp_valid_t != 2'b00) break;
            tick();
        end
        ena = 1'b1;
        check("to_en_cycles", en_cnt, 4);
        check("to_valid", rsp_valid_t, 2'b01);
        check("to_status", rsp_status_t, 2'b01);
        check("to_c_unchanged", rsp_c_t, 8'h00);
        rsp_ready_t = 2'b01;
        tick();
        rsp_ready_t = 2'b00;

        // reset in the middle of RUN
        req_valid = 2'b11; #1;
        check("prerst_ready", req_ready, 2'b10);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("midrst_busy", busy, 1'b0);
        check("midrst_outs", {req_ready, rsp_valid, rsp_status, rsa_en, rsa_clear, grant_id}, 9'b0);
        check("midrst_rsp_c", rsp_c, 8'h00);
        check("midrst_ops", {rsa_p, rsa_e, rsa_m, rsa_const}, 32'h0);
        rst = 1'b0; #1;
        check("postrst_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00; #1;
        check("postrst_clear", {grant_id, rsa_clear}, 2'b01);
        tick();
        rsa_eoc = 1'b1; rsa_c = 8'h09;
        tick();
        rsa_eoc = 1'b0; #1;
        check("postrst_rsp", {rsp_valid, rsp_status, rsp_c}, {2'b01, 2'b00, 8'h09});
        rsp_ready = 2'b01;
        tick();
        rsp_ready = 2'b00; #1;
        check("postrst_done", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/rsa_job_arbiter.md
RSA_JOB_ARBITER -- requirements
Module: rsa_job_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum RUN cycles before a job is abandoned; range 1..255.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 ena  input  1  SHALL be the global enable; low freezes all state and counters.
REQ-006 req_valid  input  2  SHALL be the per-requester job request; bit i belongs to requester i.
REQ-007 req_ready  output  2  SHALL be the per-requester one-cycle accept strobe.
REQ-008 req_p, req_e, req_m, req_const  input  2*WIDTH each  SHALL carry the operands; requester i uses slice [i*WIDTH +: WIDTH].
REQ-009 rsp_valid  output  2  SHALL be the per-requester result-valid flag.
REQ-010 rsp_ready  input  2  SHALL be the per-requester result-consumed flag.
REQ-011 rsp_c  output  WIDTH  SHALL be the result word, shared by both requesters.
REQ-012 rsp_status  output  2  SHALL be the completion code: 00 ok, 01 timeout, 10 aborted.
REQ-013 abort  input  1  SHALL request cancellation of the active job.
REQ-014 rsa_p, rsa_e, rsa_m, rsa_const  output  WIDTH each  SHALL drive the datapath operands.
REQ-015 rsa_clear  output  1  SHALL drive the datapath clear.
REQ-016 rsa_en  output  1  SHALL drive the datapath enable.
REQ-017 rsa_eoc  input  1  SHALL be the datapath end-of-computation flag.
REQ-018 rsa_c  input  WIDTH  SHALL be the datapath result.
REQ-019 busy  output  1  SHALL be high in every state except IDLE.
REQ-020 grant_id  output  1  SHALL identify the requester that owns the current job.

Function
REQ-021 The FSM SHALL have exactly the states IDLE, CLEAR, RUN and RESP.
REQ-022 In IDLE with ena=1 and any req_valid set, the block SHALL assert req_ready for the granted requester for that single cycle.
REQ-023 On that same edge it SHALL latch that requester's four operands, set grant_id, and move to CLEAR.
REQ-024 Arbitration SHALL be round-robin: with both bits set, the grant goes to the requester not granted last.
REQ-025 The round-robin pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-026 rsa_p, rsa_e, rsa_m and rsa_const SHALL present the latched operands and stay stable from CLEAR until return to IDLE.
REQ-027 CLEAR SHALL last exactly one cycle, with rsa_clear=1 and rsa_en=0, then move to RUN.
REQ-028 On entering RUN the cycle counter SHALL be 0.
REQ-029 RUN SHALL hold rsa_en=1 and increment the counter by 1 per enabled cycle.
REQ-030 In RUN, rsa_eoc=1 SHALL capture rsa_c into rsp_c, set status 00, and move to RESP.
REQ-031 In RUN, a counter value of TIMEOUT-1 with rsa_eoc=0 SHALL set status 01 and move to RESP; rsp_c keeps its previous value.
REQ-032 In CLEAR or RUN, abort=1 SHALL set status 10 and move to RESP.
REQ-033 Precedence on the same cycle SHALL be rsa_eoc over abort over timeout.
REQ-034 RESP SHALL hold rsa_en=0 and rsp_valid[grant_id]=1, with rsp_c and rsp_status stable.
REQ-035 RESP SHALL move to IDLE on the cycle rsp_ready[grant_id]=1.
REQ-036 rsp_ready on the non-granted bit SHALL be ignored.
REQ-037 abort outside CLEAR and RUN SHALL be ignored.
REQ-038 Latency from the req_ready cycle T SHALL be: CLEAR at T+1, first rsa_en at T+2, rsp_valid one cycle after the cycle in which rsa_eoc is sampled high.
REQ-039 A requester SHALL NOT be granted again until its previous response has been consumed.
REQ-040 While ena=0, the block SHALL force rsa_en=0, req_ready=0 and rsa_clear=0, and freeze the state, counter and pointer.
REQ-041 A requester deasserting req_valid before grant SHALL lose its request with no side effect.

Reset
REQ-042 With rst=1, the block SHALL go to IDLE on the next edge and abandon any job in progress without driving rsa_clear.
REQ-043 Reset values SHALL be: req_ready=0, rsp_valid=0, rsp_c=0, rsp_status=00, rsa_* outputs 0, busy=0, grant_id=0, counter=0, pointer=1.
REQ-044 rst SHALL take priority over ena and over every other input.

Verification
REQ-045 Single job: req_valid=01, operands P=0x0B E=0x07 M=0x05 Const=0x04; stub raises eoc after 10 RUN cycles with rsa_c=0x5A -> req_ready=01 at T, rsa_clear at T+1, rsp_valid=01 with rsp_c=0x5A and status 00 at T+12.
REQ-046 Contention: req_valid=11 held through two jobs -> grants go 0 then 1; grant_id toggles; each rsp_valid waits for its own rsp_ready.
REQ-047 Timeout: TIMEOUT=4, eoc never raised -> rsa_en high exactly 4 cycles, then rsp_status=01 and rsp_c unchanged.
REQ-048 Abort and eoc in the same RUN cycle -> status 00 with rsa_c captured; abort alone in CLEAR -> status 10, and rsa_en never asserted.
REQ-049 ena=0 for 5 cycles mid-RUN -> rsa_en=0 and counter frozen for those cycles; the job completes correctly afterwards.
REQ-050 rst=1 during RUN -> all outputs at reset values on the next edge; a new request afterwards is accepted normally.
